// File: rtl/i2c_reg_sequencer.sv
// Expands one host register read/write into single-byte I2C master transactions.
// Latency: accept -> first m_start 1 clk; last m_busy fall -> rsp_valid 1 clk.
// Backpressure: cmd_ready is high only while idle; a busy sequencer refuses new commands.
module i2c_reg_sequencer #(
    parameter int BUSY_TIMEOUT = 20000,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev_addr,
    input  logic [7:0] cmd_reg_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [1:0] rsp_code,
    output logic [7:0] rsp_rdata,
    output logic       m_start,
    output logic       m_rw,
    output logic [7:0] m_data_in,
    input  logic       m_busy,
    input  logic       m_ack_error,
    input  logic [7:0] m_data_out
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_NACK    = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_rw;
    logic [6:0]      r_dev;
    logic [7:0]      r_reg;
    logic [7:0]      r_wdata;
    logic [1:0]      r_idx;
    logic            r_nack_seen;
    logic [TW-1:0]   r_timer;
    logic [GW-1:0]   r_gap;
    logic            r_cmd_ready;
    logic            r_rsp_valid;
    logic [1:0]      r_rsp_code;
    logic [7:0]      r_rsp_rdata;
    logic            r_m_start;
    logic            r_m_rw;
    logic [7:0]      r_m_data_in;

    logic            w_last;
    logic            w_timer_done;

    // Returns {rw, byte} for position idx of the write (3-byte) or read (4-byte) list.
    function automatic logic [8:0] byte_sel(input logic [1:0] idx, input logic rw,
                                            input logic [6:0] dev, input logic [7:0] rg,
                                            input logic [7:0] wd);
        case (idx)
            2'd0:    byte_sel = {1'b0, dev, 1'b0};
            2'd1:    byte_sel = {1'b0, rg};
            2'd2:    byte_sel = rw ? {1'b0, dev, 1'b1} : {1'b0, wd};
            default: byte_sel = {1'b1, 8'h00};
        endcase
    endfunction

    assign w_last       = (r_idx == (r_rw ? 2'd3 : 2'd2));
    assign w_timer_done = (r_timer == TW'(BUSY_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rw        <= 1'b0;
            r_dev       <= '0;
            r_reg       <= '0;
            r_wdata     <= '0;
            r_idx       <= '0;
            r_nack_seen <= 1'b0;
            r_timer     <= '0;
            r_gap       <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_code  <= RSP_OK;
            r_rsp_rdata <= '0;
            r_m_start   <= 1'b0;
            r_m_rw      <= 1'b0;
            r_m_data_in <= '0;
        end else begin
            r_m_start   <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready            <= 1'b0;
                        r_rw                   <= cmd_rw;
                        r_dev                  <= cmd_dev_addr;
                        r_reg                  <= cmd_reg_addr;
                        r_wdata                <= cmd_wdata;
                        r_idx                  <= 2'd0;
                        r_m_start              <= 1'b1;
                        {r_m_rw, r_m_data_in}  <= byte_sel(2'd0, cmd_rw, cmd_dev_addr,
                                                           cmd_reg_addr, cmd_wdata);
                        r_state                <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_nack_seen <= 1'b0;
                    r_timer     <= '0;
                    r_state     <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (m_busy) begin
                        r_timer <= '0;
                        r_state <= S_WAIT_LO;
                    end else if (w_timer_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_code  <= RSP_TIMEOUT;
                        r_rsp_rdata <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (!m_busy) begin
                        if (r_nack_seen) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_code  <= RSP_NACK;
                            r_rsp_rdata <= '0;
                            r_state     <= S_DONE;
                        end else if (w_last) begin
                            // Only a read's final byte carries data back.
                            r_rsp_valid <= 1'b1;
                            r_rsp_code  <= RSP_OK;
                            r_rsp_rdata <= r_rw ? m_data_out : 8'h00;
                            r_state     <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                            r_gap <= '0;
                            if (GAP_CYCLES == 0) begin
                                r_m_start             <= 1'b1;
                                {r_m_rw, r_m_data_in} <= byte_sel(r_idx + 2'd1, r_rw, r_dev,
                                                                  r_reg, r_wdata);
                                r_state               <= S_ISSUE;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end
                    end else begin
                        // The master drops its error flag with busy, so hold it here.
                        r_nack_seen <= r_nack_seen | m_ack_error;
                        if (w_timer_done) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_code  <= RSP_TIMEOUT;
                            r_rsp_rdata <= '0;
                            r_state     <= S_DONE;
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (int'(r_gap) >= GAP_CYCLES - 1) begin
                        r_m_start             <= 1'b1;
                        {r_m_rw, r_m_data_in} <= byte_sel(r_idx, r_rw, r_dev, r_reg, r_wdata);
                        r_state               <= S_ISSUE;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                S_DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_code  = r_rsp_code;
    assign rsp_rdata = r_rsp_rdata;
    assign m_start   = r_m_start;
    assign m_rw      = r_m_rw;
    assign m_data_in = r_m_data_in;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: vector table of register commands against a byte-master stub,
// plus timeout, mid-command reset and held-valid sequences.
module tb_i2c_reg_sequencer;

    localparam int T   = 20000;
    localparam int GAP = 2;
    // issue + wait_hi + 3 wait_lo cycles (stub busy window) + gap
    localparam int START_PERIOD = 5 + GAP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_dev_addr = '0;
    logic [7:0] cmd_reg_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [1:0] rsp_code;
    logic [7:0] rsp_rdata;
    logic       m_start;
    logic       m_rw;
    logic [7:0] m_data_in;
    logic       m_busy;
    logic       m_ack_error;
    logic [7:0] m_data_out;

    i2c_reg_sequencer #(.BUSY_TIMEOUT(T), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_rdata(rsp_rdata),
        .m_start(m_start), .m_rw(m_rw), .m_data_in(m_data_in),
        .m_busy(m_busy), .m_ack_error(m_ack_error), .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rw;
        logic [6:0]  dev;
        logic [7:0]  rg;
        logic [7:0]  wd;
        int          nack;
        logic [7:0]  rd;
        int          n;
        logic [31:0] seq;
        logic [3:0]  rwm;
        logic [1:0]  code;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs[7];

    int nchk = 0;
    int nfail = 0;
    int cmd_id = 0;
    int stub_mode = 0;
    int nack_idx = -1;
    logic [7:0] rd_byte = 8'h00;
    int acc_cyc = 0;
    int ready_viol = 0;

    // Monitor: logs start pulses and responses per command.
    int mon_id = 0, n_starts = 0, last_start_cyc = 0, gap_err = 0;
    int rsp_cnt = 0, rsp_cyc = 0;
    logic [31:0] got_seq = '0;
    logic [3:0]  got_rwm = '0;
    logic [1:0]  got_code = '0;
    logic [7:0]  got_rdata = '0;

    initial forever begin
        @(negedge clk);
        if (cmd_id != mon_id) begin
            mon_id = cmd_id; n_starts = 0; got_seq = '0; got_rwm = '0; gap_err = 0;
        end
        if (m_start) begin
            if (n_starts > 0 && (cyc - last_start_cyc) != START_PERIOD) gap_err++;
            if (n_starts < 4) begin
                got_seq = got_seq | ({24'h0, m_data_in} << (24 - 8 * n_starts));
                got_rwm = got_rwm | (4'(m_rw) << n_starts);
            end
            n_starts++;
            last_start_cyc = cyc;
        end
        if (rsp_valid) begin
            rsp_cnt++; rsp_cyc = cyc; got_code = rsp_code; got_rdata = rsp_rdata;
        end
    end

    // Master stub: mode 0 = 4-cycle busy window, 1 = never busy, 2 = busy stuck high.
    int stub_id = 0, stub_idx = 0, fall_cyc = 0, stab_err = 0;
    logic [7:0] s_dat;
    logic       s_rw;
    logic       s_nk;

    initial begin
        m_busy = 1'b0; m_ack_error = 1'b0; m_data_out = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (rst_n && m_start) begin
                if (stub_id != cmd_id) begin stub_id = cmd_id; stub_idx = 0; end
                s_dat = m_data_in; s_rw = m_rw; s_nk = (stub_idx == nack_idx);
                stub_idx++;
                if (stub_mode == 2) begin
                    m_busy = 1'b1;
                    while (stub_mode == 2 && rst_n) begin @(posedge clk); #1; end
                    m_busy = 1'b0;
                end else if (stub_mode == 0) begin
                    m_busy = 1'b1; m_data_out = rd_byte;
                    for (int k = 0; k < 4; k++) begin
                        @(posedge clk); #1;
                        if (!rst_n) break;
                        if (m_data_in !== s_dat || m_rw !== s_rw) stab_err++;
                        m_ack_error = s_nk && (k == 1);
                    end
                    m_busy = 1'b0; m_ack_error = 1'b0; fall_cyc = cyc;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic start_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [7:0] wd);
        int i;
        cmd_id++;
        cmd_rw = rw; cmd_dev_addr = dev; cmd_reg_addr = rg; cmd_wdata = wd; cmd_valid = 1'b1;
        i = 0;
        while (!cmd_ready && i < 200) begin @(posedge clk); #1; i++; end
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        chk("start_latency", 32'(m_start), 32'd1);
        cmd_valid = 1'b0;
        cmd_rw = ~rw; cmd_dev_addr = ~dev; cmd_reg_addr = ~rg; cmd_wdata = ~wd;
    endtask

    task automatic wait_rsp(input int budget);
        int base, i;
        base = rsp_cnt; ready_viol = 0; i = 0;
        while (rsp_cnt == base && i < budget) begin
            @(negedge clk); #1;
            if (rsp_cnt == base && cmd_ready) ready_viol++;
            i++;
        end
        chk("rsp_count", 32'(rsp_cnt - base), 32'd1);
        @(negedge clk); #1;
        chk("rsp_pulse_width", 32'(rsp_valid), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        stub_mode = 0; nack_idx = v.nack; rd_byte = v.rd;
        start_cmd(v.rw, v.dev, v.rg, v.wd);
        wait_rsp(500);
        chk({tag, "_starts"}, 32'(n_starts), 32'(v.n));
        chk({tag, "_bytes"}, got_seq, v.seq);
        chk({tag, "_rw"}, 32'(got_rwm), 32'(v.rwm));
        chk({tag, "_code"}, 32'(got_code), 32'(v.code));
        chk({tag, "_rdata"}, 32'(got_rdata), 32'(v.rdata));
        chk({tag, "_code_held"}, 32'(rsp_code), 32'(v.code));
        chk({tag, "_rdata_held"}, 32'(rsp_rdata), 32'(v.rdata));
        chk({tag, "_ready_busy"}, 32'(ready_viol), 32'd0);
        chk({tag, "_gap"}, 32'(gap_err), 32'd0);
        chk({tag, "_rsp_latency"}, 32'(rsp_cyc - fall_cyc), 32'd1);
        chk({tag, "_stable"}, 32'(stab_err), 32'd0);
    endtask

    initial begin
        //           rw    dev    reg    wdata  nack rd     n  bytes         rwm      code   rdata
        vecs[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, -1, 8'h00, 3, 32'hA010A500, 4'b0000, 2'b00, 8'h00};
        vecs[1] = '{1'b1, 7'h50, 8'h22, 8'h00, -1, 8'h3C, 4, 32'hA022A100, 4'b1000, 2'b00, 8'h3C};
        vecs[2] = '{1'b0, 7'h50, 8'h10, 8'hA5,  1, 8'h00, 2, 32'hA0100000, 4'b0000, 2'b01, 8'h00};
        vecs[3] = '{1'b1, 7'h50, 8'h22, 8'h00,  3, 8'h3C, 4, 32'hA022A100, 4'b1000, 2'b01, 8'h00};
        vecs[4] = '{1'b1, 7'h7F, 8'hFF, 8'h00, -1, 8'h81, 4, 32'hFEFFFF00, 4'b1000, 2'b00, 8'h81};
        vecs[5] = '{1'b0, 7'h00, 8'h00, 8'hFF,  0, 8'h00, 1, 32'h00000000, 4'b0000, 2'b01, 8'h00};
        vecs[6] = '{1'b0, 7'h12, 8'h34, 8'h56, -1, 8'h99, 3, 32'h24345600, 4'b0000, 2'b00, 8'h00};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_code", 32'(rsp_code), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_m_data_in", 32'(m_data_in), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 32'(cmd_ready), 32'd1);

        for (int v = 0; v < 7; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        // Held cmd_valid with new fields: ignored until the first response, then accepted.
        stub_mode = 0; nack_idx = -1; rd_byte = 8'h5E;
        start_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_dev_addr = 7'h33; cmd_reg_addr = 8'h44;
        wait_rsp(500);
        chk("hold_first_ready_busy", 32'(ready_viol), 32'd0);
        chk("hold_first_starts", 32'(n_starts), 32'd3);
        chk("hold_first_bytes", got_seq, 32'hA010A500);
        chk("hold_first_code", 32'(got_code), 32'd0);
        cmd_id++;
        chk("hold_ready_after_rsp", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        chk("hold_second_start", 32'(m_start), 32'd1);
        chk("hold_second_accept_cyc", 32'(acc_cyc - rsp_cyc), 32'd2);
        cmd_valid = 1'b0;
        wait_rsp(500);
        chk("hold_second_starts", 32'(n_starts), 32'd4);
        chk("hold_second_bytes", got_seq, 32'h66446700);
        chk("hold_second_rw", 32'(got_rwm), 32'b1000);
        chk("hold_second_code", 32'(got_code), 32'd0);
        chk("hold_second_rdata", 32'(got_rdata), 32'h5E);

        // Master never raises busy.
        stub_mode = 1;
        start_cmd(1'b0, 7'h50, 8'h10, 8'h5A);
        wait_rsp(T + 100);
        chk("to_hi_latency", 32'(rsp_cyc - acc_cyc), 32'(T + 2));
        chk("to_hi_code", 32'(got_code), 32'd2);
        chk("to_hi_rdata", 32'(got_rdata), 32'd0);
        chk("to_hi_starts", 32'(n_starts), 32'd1);

        // Master busy never falls.
        stub_mode = 2; rd_byte = 8'h77;
        start_cmd(1'b1, 7'h50, 8'h22, 8'h00);
        wait_rsp(T + 100);
        chk("to_lo_latency", 32'(rsp_cyc - acc_cyc), 32'(T + 3));
        chk("to_lo_code", 32'(got_code), 32'd2);
        chk("to_lo_rdata", 32'(got_rdata), 32'd0);
        stub_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        // Reset while the third byte of a write is in its busy window.
        nack_idx = -1; rd_byte = 8'h00;
        start_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        begin
            int i, base;
            i = 0;
            while (n_starts < 3 && i < 200) begin @(negedge clk); #1; i++; end
            chk("rst_reach_byte2", 32'(n_starts), 32'd3);
            @(posedge clk); #1;
            @(posedge clk); #1;
            base = rsp_cnt;
            rst_n = 1'b0;
            #1;
            chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("midrst_rsp_code", 32'(rsp_code), 32'd0);
            chk("midrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
            chk("midrst_m_start", 32'(m_start), 32'd0);
            chk("midrst_m_rw", 32'(m_rw), 32'd0);
            chk("midrst_m_data_in", 32'(m_data_in), 32'd0);
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            chk("midrst_ready_at_release", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
            chk("midrst_ready_after_clk", 32'(cmd_ready), 32'd1);
            repeat (20) @(posedge clk);
            #1;
            chk("midrst_no_rsp", 32'(rsp_cnt - base), 32'd0);
        end
        run_vec(vecs[1], "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
